ram_arbitro: RTL

RAM_ARBITRO -- requirements
Module: ram_arbitro

---
 rtl/ram_arbitro_pkg.sv | 14 +
 rtl/ram_arbitro_rr.sv | 17 +
 rtl/ram_arbitro.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ram_arbitro_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   BITS_DEF     : default MSB index of address/data buses
//   MEM_SIZE_DEF : default index of the last valid RAM cell
//   estado_t     : arbiter FSM state encoding
package ram_arbitro_pkg;
  localparam int BITS_DEF     = 63;
  localparam int MEM_SIZE_DEF = 31;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONCEDE  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;
endpackage

// File: rtl/ram_arbitro_rr.sv
// Two-requester round-robin winner selection (purely combinational).
//   req0, req1 : pending requests
//   last       : index of the requester served most recently
//   winner     : index of the requester to grant (meaningful only if a req is high)
module ram_arbitro_rr (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);
  // Contention goes to whoever was not served last; otherwise the lone requester.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last;
    else              winner = req1;
  end
endmodule

// File: rtl/ram_arbitro.sv
// Arbiter granting two requesters access to a single external synchronous-write,
// combinational-read RAM. Each transaction takes exactly three cycles:
// OCIOSO (sample/latch) -> CONCEDE (RAM access) -> RESPONDE (ack pulse).
//   clock, reset_n          : clock, asynchronous active-low reset
//   reqK/weK/endK/dadoK     : request, write flag, address, write data of requester K
//   ackK/erroK/leituraK     : completion pulse, out-of-range flag, registered read data
//   mem_*                   : RAM write enable, address, write data, read data
module ram_arbitro
  import ram_arbitro_pkg::*;
#(
  parameter int BITS     = BITS_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [BITS:0] end0,
  input  logic [BITS:0] end1,
  input  logic [BITS:0] dado0,
  input  logic [BITS:0] dado1,
  output logic          ack0,
  output logic          ack1,
  output logic          erro0,
  output logic          erro1,
  output logic [BITS:0] leitura0,
  output logic [BITS:0] leitura1,
  output logic          mem_permisao_escrita,
  output logic [BITS:0] mem_endereco,
  output logic [BITS:0] mem_dado_escrita,
  input  logic [BITS:0] mem_dado_leitura
);
  localparam logic [BITS:0] MEM_LIM = (BITS+1)'(MEM_SIZE);

  estado_t       estado_q, estado_d;
  logic          vence_q, vence_d;   // latched winner index
  logic          we_q, we_d;
  logic [BITS:0] end_q, end_d;
  logic [BITS:0] dado_q, dado_d;
  logic [BITS:0] leit0_q, leit0_d;
  logic [BITS:0] leit1_q, leit1_d;
  logic          last_q, last_d;     // last served requester
  logic          rr_win;
  logic          em_faixa;
  logic [BITS:0] rd_dado;

  ram_arbitro_rr u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (rr_win)
  );

  assign em_faixa = (end_q <= MEM_LIM);

  // The latched address/data only change when a new transaction is accepted,
  // so driving the RAM buses from them gives "hold last value" outside CONCEDE.
  assign mem_endereco     = end_q;
  assign mem_dado_escrita = dado_q;
  assign leitura0         = leit0_q;
  assign leitura1         = leit1_q;

  always_comb begin
    estado_d             = estado_q;
    vence_d              = vence_q;
    we_d                 = we_q;
    end_d                = end_q;
    dado_d               = dado_q;
    leit0_d              = leit0_q;
    leit1_d              = leit1_q;
    last_d               = last_q;
    rd_dado              = '0;
    mem_permisao_escrita = 1'b0;
    ack0                 = 1'b0;
    ack1                 = 1'b0;
    erro0                = 1'b0;
    erro1                = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (req0 || req1) begin
          vence_d  = rr_win;
          we_d     = rr_win ? we1   : we0;
          end_d    = rr_win ? end1  : end0;
          dado_d   = rr_win ? dado1 : dado0;
          estado_d = CONCEDE;
        end
      end
      CONCEDE: begin
        // Enable is decoded from state so an async reset drops it immediately.
        mem_permisao_escrita = we_q && em_faixa;
        rd_dado              = em_faixa ? mem_dado_leitura : '0;
        if (vence_q) leit1_d = rd_dado;
        else         leit0_d = rd_dado;
        last_d   = vence_q;
        estado_d = RESPONDE;
      end
      RESPONDE: begin
        ack0     = ~vence_q;
        ack1     = vence_q;
        erro0    = ~vence_q && !em_faixa;
        erro1    = vence_q && !em_faixa;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      vence_q  <= 1'b0;
      we_q     <= 1'b0;
      end_q    <= '0;
      dado_q   <= '0;
      leit0_q  <= '0;
      leit1_q  <= '0;
      last_q   <= 1'b1;  // requester 1 "served last" => requester 0 favoured
    end else begin
      estado_q <= estado_d;
      vence_q  <= vence_d;
      we_q     <= we_d;
      end_q    <= end_d;
      dado_q   <= dado_d;
      leit0_q  <= leit0_d;
      leit1_q  <= leit1_d;
      last_q   <= last_d;
    end
  end
endmodule
